// File: rtl/cte_yuv422_packer.sv
// cte_yuv422_packer
// Feeds RGB pixels to the CTE converter in pairs (RGB-to-YUV mode). It then
// gathers the U, Y0, V, Y1 bytes that CTE returns and packs each group into
// one 32-bit 4:2:2 word. Packed words wait in a small FIFO until the
// downstream port takes them.
// A new pair is started only when the FIFO is sure to have room for its word.
// This credit check keeps downstream backpressure away from CTE.

module cte_yuv422_packer #(
  parameter int DEPTH   = 4,
  parameter bit PAD_DUP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_rgb,
  input  logic        s_last,
  output logic        cte_op_mode,
  output logic        cte_in_en,
  output logic [23:0] cte_rgb_in,
  input  logic        cte_busy,
  input  logic        cte_out_valid,
  input  logic [7:0]  cte_yuv_out,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SEND0 = 3'd1;
  localparam logic [2:0] WAIT1 = 3'd2;
  localparam logic [2:0] SEND1 = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] PAD   = 3'd5;

  // Pair sequencing state
  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        started;
  logic [23:0] pix0;
  logic [23:0] pix1;
  logic [23:0] rgb_hold;
  logic [23:0] drive_rgb;
  logic        pair_last;
  logic        inflight;
  logic        wait1_new;
  logic        wait1_en;

  // Byte capture state
  logic [1:0]  phase;
  logic [23:0] asm_q;
  logic        byte_ok;
  logic        spurious;
  logic        push_req;

  // Word FIFO: an output register holds the head word, and the memory
  // holds the words queued behind it
  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_count;
  logic [CW-1:0] fifo_count;
  logic          credit_ok;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  logic          load_out;
  logic          mem_rd;
  logic          mem_wr;
  logic          bypass;

  assign cte_op_mode = 1'b1;

  assign fifo_count = mem_count + CW'(m_valid);
  assign credit_ok  = (fifo_count + CW'(inflight)) < CW'(DEPTH);

  // A byte is accepted only while a pair is outstanding or a word is
  // partly built. Any other byte is flagged as spurious and discarded.
  assign byte_ok  = cte_out_valid && (inflight || (phase != 2'd0));
  assign spurious = cte_out_valid && !inflight && (phase == 2'd0);
  assign push_req = byte_ok && (phase == 2'd3);

  assign pop       = m_valid && m_ready;
  assign push_ok   = push_req && ((fifo_count < CW'(DEPTH)) || pop);
  assign push_drop = push_req && !push_ok;
  assign load_out  = !m_valid || pop;
  assign mem_rd    = load_out && (mem_count != '0);
  assign bypass    = push_ok && load_out && (mem_count == '0);
  assign mem_wr    = push_ok && !bypass;

  // CTE sees the pixel being issued during a strobe and the last issued pixel otherwise
  assign cte_rgb_in = cte_in_en ? drive_rgb : rgb_hold;

  // Next-state logic and the handshake and strobe outputs for the pair sequencer
  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    cte_in_en = 1'b0;
    drive_rgb = rgb_hold;
    case (state)
      IDLE: begin
        s_ready = started && credit_ok;
        if (s_valid && started && credit_ok) begin
          state_nx = SEND0;
        end
      end
      SEND0: begin
        drive_rgb = pix0;
        if (!cte_busy) begin
          cte_in_en = 1'b1;
          state_nx  = pair_last ? PAD : WAIT1;
        end
      end
      WAIT1: begin
        s_ready = !cte_busy;
        if (s_valid && !cte_busy) begin
          state_nx = SEND1;
        end
      end
      SEND1: begin
        drive_rgb = pix1;
        if (!cte_busy) begin
          cte_in_en = 1'b1;
          state_nx  = DRAIN;
        end
      end
      PAD: begin
        drive_rgb = PAD_DUP ? pix0 : 24'h000000;
        if (!cte_busy) begin
          cte_in_en = 1'b1;
          state_nx  = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight || push_req) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer registers: state, held pixels, the frame-end flag and inflight credit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      started   <= 1'b0;
      pix0      <= 24'h000000;
      pix1      <= 24'h000000;
      rgb_hold  <= 24'h000000;
      pair_last <= 1'b0;
      inflight  <= 1'b0;
      wait1_new <= 1'b0;
      wait1_en  <= 1'b0;
    end else begin
      state     <= state_nx;
      started   <= 1'b1;
      wait1_new <= (state_nx == WAIT1) && (state != WAIT1);
      wait1_en  <= cte_in_en;
      if (cte_in_en) begin
        rgb_hold <= drive_rgb;
      end
      if (state == IDLE && s_valid && s_ready) begin
        pix0      <= s_rgb;
        pair_last <= s_last;
      end
      if (state == WAIT1 && s_valid && s_ready) begin
        pix1      <= s_rgb;
        pair_last <= s_last;
      end
      if (push_req) begin
        inflight <= 1'b0;
      end
      if (state == SEND0 && cte_in_en) begin
        inflight <= 1'b1;
      end
    end
  end

  // Collect U, Y0 and V into the assembly register. Y1 joins them on the way into the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 2'd0;
      asm_q <= 24'h000000;
    end else if (byte_ok) begin
      phase <= phase + 2'd1;
      case (phase)
        2'd0:    asm_q[23:16] <= cte_yuv_out;
        2'd1:    asm_q[15:8]  <= cte_yuv_out;
        2'd2:    asm_q[7:0]   <= cte_yuv_out;
        default: ;
      endcase
    end
  end

  // FIFO storage behind the output register. It has no reset, because only written entries are ever read.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr] <= {pair_last, asm_q, cte_yuv_out};
    end
  end

  // FIFO pointers, occupancy and the registered first-word-fall-through head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      m_valid   <= 1'b0;
      m_data    <= 32'h00000000;
      m_last    <= 1'b0;
    end else begin
      mem_count <= mem_count + CW'(mem_wr) - CW'(mem_rd);
      if (mem_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (load_out) begin
        if (mem_count != '0) begin
          m_valid <= 1'b1;
          m_data  <= mem_q[rd_ptr][31:0];
          m_last  <= mem_q[rd_ptr][32];
        end else if (push_ok) begin
          m_valid <= 1'b1;
          m_data  <= {asm_q, cte_yuv_out};
          m_last  <= pair_last;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  // Sticky protocol error: a stray byte, a dropped word, or CTE busy on an unprompted WAIT1 entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (spurious || push_drop || (wait1_new && cte_busy && !wait1_en)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cte_yuv422_packer.sv
// tb_cte_yuv422_packer
// Directed bench for cte_yuv422_packer. A small CTE model returns U, Y0, V, Y1
// with the documented timing. Its bytes are derived from the issued pixels,
// so that word order and content can be told apart.

module tb_cte_yuv422_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_rgb;
  logic        s_last;
  logic        cte_op_mode;
  logic        cte_in_en;
  logic [23:0] cte_rgb_in;
  logic        cte_busy;
  logic        cte_out_valid;
  logic [7:0]  cte_yuv_out;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        err;

  int tests = 0;
  int fails = 0;

  // CTE model state and observation points
  logic        mdl_active;
  logic        mdl_valid;
  logic        mdl_got1;
  logic [7:0]  mdl_byte;
  logic [23:0] mdl_p0;
  logic [23:0] mdl_p1;
  logic        overlap;
  logic        inj_valid;
  logic [7:0]  tb_u;
  logic [7:0]  tb_y0;
  logic [7:0]  tb_v;
  logic [7:0]  tb_y1;
  int          mdl_k;
  int          p1_k;
  int          extra_busy;
  int          en_count;
  int          cyc = 0;
  int          en0_cyc = 0;
  int          mv_cyc = 0;
  logic        mv_prev = 1'b0;

  assign cte_out_valid = mdl_valid | inj_valid;
  assign cte_yuv_out   = inj_valid ? 8'hEE : mdl_byte;

  always #5 clk = ~clk;

  cte_yuv422_packer #(.DEPTH(4), .PAD_DUP(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_rgb         (s_rgb),
    .s_last        (s_last),
    .cte_op_mode   (cte_op_mode),
    .cte_in_en     (cte_in_en),
    .cte_rgb_in    (cte_rgb_in),
    .cte_busy      (cte_busy),
    .cte_out_valid (cte_out_valid),
    .cte_yuv_out   (cte_yuv_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .err           (err)
  );

  // Cycle counter and the cycle in which m_valid first rises
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    mv_prev <= m_valid;
    if (m_valid && !mv_prev) mv_cyc <= cyc;
  end

  // CTE model: U follows pixel0 by one cycle, then Y0 and V follow.
  // Busy is held for 1+extra_busy cycles. Y1 comes no earlier than cycle 4
  // and only once pixel1 has arrived.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_active <= 1'b0;
      mdl_valid  <= 1'b0;
      mdl_got1   <= 1'b0;
      mdl_byte   <= 8'h00;
      mdl_p0     <= 24'h0;
      mdl_p1     <= 24'h0;
      cte_busy   <= 1'b0;
      overlap    <= 1'b0;
      mdl_k      <= 0;
      p1_k       <= 0;
      en_count   <= 0;
    end else begin
      mdl_valid <= 1'b0;
      if (cte_in_en) en_count <= en_count + 1;
      if (cte_in_en && cte_busy) overlap <= 1'b1;
      if (!mdl_active) begin
        cte_busy <= 1'b0;
        if (cte_in_en) begin
          mdl_active <= 1'b1;
          mdl_k      <= 1;
          mdl_got1   <= 1'b0;
          mdl_p0     <= cte_rgb_in;
          en0_cyc    <= cyc;
          cte_busy   <= 1'b1;
          mdl_valid  <= 1'b1;
          mdl_byte   <= tb_u + cte_rgb_in[7:0];
        end
      end else begin
        mdl_k    <= mdl_k + 1;
        cte_busy <= ((mdl_k + 1) <= (1 + extra_busy));
        if (cte_in_en) begin
          mdl_got1 <= 1'b1;
          mdl_p1   <= cte_rgb_in;
          p1_k     <= mdl_k;
        end
        if (mdl_k + 1 == 2) begin
          mdl_valid <= 1'b1;
          mdl_byte  <= tb_y0;
        end else if (mdl_k + 1 == 3) begin
          mdl_valid <= 1'b1;
          mdl_byte  <= tb_v;
        end else if ((mdl_got1 || cte_in_en) && (mdl_k + 1 >= 4)) begin
          mdl_valid  <= 1'b1;
          mdl_byte   <= tb_y1 + (mdl_got1 ? mdl_p1[7:0] : cte_rgb_in[7:0]);
          mdl_active <= 1'b0;
          cte_busy   <= 1'b0;
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one pixel and wait, within a budget, for it to be taken
  task automatic applyStimulus(input logic [23:0] rgb, input logic last, input int budget,
                               output logic ok);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_rgb   = rgb;
    s_last  = last;
    while (!s_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = s_ready;
    if (ok) @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait for a word at the output and check its contents
  task automatic waitWord(input string tag, input logic [31:0] exp_data, input logic exp_last,
                          input int budget);
    int n;
    n = 0;
    while (m_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " valid"}, 32'(m_valid), 32'd1);
    checkOutput({tag, " data"}, m_data, exp_data);
    checkOutput({tag, " last"}, 32'(m_last), 32'(exp_last));
    @(negedge clk);
  endtask

  initial begin
    logic ok;
    int   acc;
    int   en_base;
    int   mv_seen;
    bit   stop;

    reset      = 1'b0;
    s_valid    = 1'b0;
    s_rgb      = 24'h0;
    s_last     = 1'b0;
    m_ready    = 1'b0;
    inj_valid  = 1'b0;
    extra_busy = 0;
    tb_u       = 8'h5A;
    tb_y0      = 8'h4C;
    tb_v       = 8'hFF;
    tb_y1      = 8'h96;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst in_en", 32'(cte_in_en), 32'd0);
    checkOutput("rst rgb_in", 32'(cte_rgb_in), 32'd0);
    checkOutput("rst m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst m_data", m_data, 32'd0);
    checkOutput("rst m_last", 32'(m_last), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("op_mode", 32'(cte_op_mode), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle s_ready", 32'(s_ready), 32'd1);

    // Test 1: single pair
    m_ready = 1'b1;
    applyStimulus(24'hFF0000, 1'b0, 20, ok);
    checkOutput("t1 accept p0", 32'(ok), 32'd1);
    applyStimulus(24'h00FF00, 1'b1, 20, ok);
    checkOutput("t1 accept p1", 32'(ok), 32'd1);
    waitWord("t1 word", 32'h5A4CFF96, 1'b1, 20);
    checkOutput("t1 latency", 32'(mv_cyc - en0_cyc), 32'd5);
    checkOutput("t1 cte p0", 32'(mdl_p0), 32'hFF0000);
    checkOutput("t1 cte p1", 32'(mdl_p1), 32'h00FF00);

    // Test 2: odd frame with the tail pixel duplicated
    m_ready = 1'b0;
    applyStimulus(24'h000011, 1'b0, 20, ok);
    applyStimulus(24'h000022, 1'b0, 20, ok);
    applyStimulus(24'h000033, 1'b1, 20, ok);
    checkOutput("t2 accept", 32'(ok), 32'd1);
    m_ready = 1'b1;
    waitWord("t2 word1", 32'h6B4CFFB8, 1'b0, 20);
    waitWord("t2 word2", 32'h8D4CFFC9, 1'b1, 20);
    checkOutput("t2 pad p0", 32'(mdl_p0), 32'h000033);
    checkOutput("t2 pad p1", 32'(mdl_p1), 32'h000033);
    checkOutput("t2 pad cycle", 32'(p1_k), 32'd2);

    // Test 3: backpressure fills the FIFO to its credit limit
    m_ready = 1'b0;
    en_base = en_count;
    acc     = 0;
    stop    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!stop) begin
        applyStimulus(24'(i), 1'b0, 30, ok);
        if (ok) acc++;
        else stop = 1'b1;
      end
    end
    repeat (4) @(negedge clk);
    checkOutput("t3 accepted", 32'(acc), 32'd8);
    checkOutput("t3 in_en count", 32'(en_count - en_base), 32'd8);
    checkOutput("t3 s_ready held", 32'(s_ready), 32'd0);
    checkOutput("t3 head data", m_data, 32'h5A4CFF97);
    m_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      waitWord($sformatf("t3 word%0d", j),
               {8'(8'h5A + 2 * j), 8'h4C, 8'hFF, 8'(8'h97 + 2 * j)}, 1'b0, 5);
    end
    @(negedge clk);
    checkOutput("t3 empty", 32'(m_valid), 32'd0);

    // Test 4: busy held longer after pixel0
    extra_busy = 3;
    applyStimulus(24'h000010, 1'b0, 20, ok);
    applyStimulus(24'h000020, 1'b1, 20, ok);
    waitWord("t4 word", 32'h6A4CFFB6, 1'b1, 20);
    checkOutput("t4 p1 cycle", 32'(p1_k), 32'd6);
    checkOutput("t4 overlap", 32'(overlap), 32'd0);
    checkOutput("t4 err", 32'(err), 32'd0);
    extra_busy = 0;

    // Test 5: stray byte with nothing in flight
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5 err set", 32'(err), 32'd1);
    checkOutput("t5 no word", 32'(m_valid), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t5 err sticky", 32'(err), 32'd1);
    checkOutput("t5 still no word", 32'(m_valid), 32'd0);

    // Test 6: reset after U and Y0 are captured
    applyStimulus(24'h000001, 1'b0, 20, ok);
    applyStimulus(24'h000002, 1'b1, 20, ok);
    checkOutput("t6 at V cycle", 32'(mdl_k), 32'd3);
    reset = 1'b0;
    #1;
    checkOutput("t6 s_ready", 32'(s_ready), 32'd0);
    checkOutput("t6 in_en", 32'(cte_in_en), 32'd0);
    checkOutput("t6 rgb_in", 32'(cte_rgb_in), 32'd0);
    checkOutput("t6 m_valid", 32'(m_valid), 32'd0);
    checkOutput("t6 m_data", m_data, 32'd0);
    checkOutput("t6 m_last", 32'(m_last), 32'd0);
    checkOutput("t6 err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    mv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_valid) mv_seen++;
    end
    checkOutput("t6 no stale word", 32'(mv_seen), 32'd0);
    applyStimulus(24'h000005, 1'b0, 20, ok);
    applyStimulus(24'h000007, 1'b1, 20, ok);
    waitWord("t6 word", 32'h5F4CFF9D, 1'b1, 20);
    checkOutput("t6 err after", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cte_yuv422_packer.md
Name: cte_yuv422_packer

Overview:
- Host-side driver and collector for the CTE converter in RGB-to-YUV mode (op_mode=1). Sits between it and the rest of the datapath.
- Takes RGB pixels from an upstream valid/ready stream and issues them to CTE in pairs, obeying CTE's busy.
- Captures CTE's serial byte stream U, Y0, V, Y1 and packs each group of four bytes into one 32-bit 4:2:2 macropixel word.
- Buffers packed words in a small FIFO ahead of a downstream valid/ready port. Backpressure reaches the converter side through credit accounting.

Parameters:
DEPTH, 4, word FIFO entries (power of 2, >=2)
PAD_DUP, 1, 1: odd tail pixel padded by duplicating it; 0: padded with black (24'h000000)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
s_valid  in  1  upstream RGB pixel valid
s_ready  out  1  upstream ready
s_rgb  in  24  pixel {R[23:16],G[15:8],B[7:0]}
s_last  in  1  last pixel of frame
cte_op_mode  out  1  constant 1
cte_in_en  out  1  pixel strobe to CTE
cte_rgb_in  out  24  pixel to CTE
cte_busy  in  1  CTE busy
cte_out_valid  in  1  CTE byte valid
cte_yuv_out  in  8  CTE output byte
m_valid  out  1  packed word valid
m_ready  in  1  downstream ready
m_data  out  32  {U[31:24],Y0[23:16],V[15:8],Y1[7:0]}
m_last  out  1  word holds the frame's last pixel(s)
err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, asynchronous), all outputs and state: s_ready=0, cte_in_en=0, cte_rgb_in=0, m_valid=0, m_data=0, m_last=0, err=0; FIFO empty; FSM in IDLE. cte_op_mode is 1 always.
- FSM states: IDLE, SEND0, WAIT1, SEND1, DRAIN, PAD.
- IDLE: issue a pair only when credit is available, i.e. fifo_count + inflight < DEPTH (inflight is 0 or 1 word). Then s_ready=1. On s_valid&&s_ready, go to SEND0 holding the pixel.
- SEND0: cte_in_en=1 for exactly one cycle with pixel0, and inflight becomes 1.
  - If the held pixel had s_last=1, go to PAD.
  - Otherwise go to WAIT1 with s_ready=1.
- WAIT1: accept pixel1 when s_valid is high and cte_busy=0, then go to SEND1. Per CTE timing, busy is high the cycle after pixel0, so the earliest SEND1 is 2 cycles after SEND0.
- PAD: in the first cycle with cte_busy=0, drive cte_in_en=1 with the pad pixel (copy of pixel0 if PAD_DUP=1, else 0). Mark the pair last, then go to DRAIN.
- SEND1: cte_in_en=1 for one cycle with pixel1, then go to DRAIN.
- DRAIN: go to IDLE when the Y1 byte has been captured.
- cte_in_en is never asserted while cte_busy=1. cte_rgb_in holds its value when in_en=0.
- Byte capture: a 2-bit phase counter advances on each cte_out_valid. Phase 0..3 write U, Y0, V, Y1 into the assembly register. On phase 3 the word plus its last flag is pushed to the FIFO, inflight clears, and the phase wraps to 0.
- Latency: pixel0 in_en at cycle t gives U at t+1, Y0 t+2, V t+3, Y1 t+4. m_valid rises at t+5 when the FIFO was empty.
- FIFO:
  - Output is registered, first-word-fall-through.
  - Pop on m_valid&&m_ready.
  - Simultaneous push and pop at full is legal, because credit guarantees push space.
  - Push when full is impossible by credit; if it occurs, set err and drop the word.
- err (sticky until reset) is set when:
  - cte_out_valid arrives while inflight=0 and phase=0, or
  - cte_busy=1 when WAIT1 is entered from a state in which no in_en was issued.
- Frame: m_last=1 on the word containing the s_last pixel. After s_last the FSM returns to IDLE normally; there is no flush.
- Reset mid-operation: everything clears immediately, a partial word is discarded, and no m_valid follows.

Test Plan:
1. Single pair: s_rgb=24'hFF0000 then 24'h00FF00, m_ready=1, CTE model returns U=8'h5A, Y0=8'h4C, V=8'hFF, Y1=8'h96 -> one word m_data=32'h5A4CFF96, m_valid at t+5, m_last per s_last.
2. Odd frame: 3 pixels with s_last on the third, PAD_DUP=1 -> 2 words; the second word's CTE inputs are pixel2 twice; m_last=1 only on word 2.
3. Backpressure: m_ready=0, 10 pixels offered, DEPTH=4 -> exactly 4 words buffered, s_ready stays 0 afterwards, cte_in_en count=8; release m_ready -> words drain in order with none lost.
4. Busy obedience: CTE model holds busy high for 3 extra cycles after pixel0 -> cte_in_en for pixel1 waits, never overlapping busy=1.
5. Spurious byte: cte_out_valid pulse with nothing in flight -> err=1 and stays 1; no m_valid.
6. Async reset asserted after U and Y0 captured -> all outputs 0 within the reset cycle; after release, a new pair produces a clean word with no stale bytes.
